serial_word_tx: RTL and testbench
=================================

// Module: serial_word_tx
// PURPOSE
//  Parallel-in, serial-out word transmitter with a valid/ready load handshake.
//  Serialises one WIDTH-bit word per transfer onto a 1-bit data line, with a frame strobe.
//  Forms the sending end of the lab's bit-serial link; the paired serial receiver reassembles words.
//  Single clock domain; all outputs registered except in_ready.
// PARAMETERS
//  WIDTH       8   word width in bits; legal range 2..32
//  MSB_FIRST   0   0 = bit 0 sent first; 1 = bit WIDTH-1 sent first
//  GAP_CYCLES  1   idle cycles (sframe=0) forced after each word; legal range 0..15
// PORTS
//  clk       in   1      clock; all state changes on rising edge
//  rst       in   1      asynchronous, active-low reset (rst=0 resets immediately)
//  in_data   in   WIDTH  word to send; sampled only on the accepting edge
//  in_valid  in   1      upstream has a word
//  in_ready  out  1      transmitter can accept; equals (state==IDLE)
//  sdata     out  1      serial data bit
//  sframe    out  1      high exactly during the WIDTH bit cycles of a word
//  busy      out  1      high in SHIFT and GAP
//  done      out  1      1-cycle pulse in the cycle after the last bit
// BEHAVIOUR
//  - Reset (rst=0, asynchronous): state=IDLE, shift reg=0, bit count=0, gap count=0;
//    sdata=0, sframe=0, busy=0, done=0; in_ready=1 once rst is released.
//  - Accept: rising edge with in_valid=1 && in_ready=1. Load in_data into the shift reg; go to SHIFT.
//  - States: IDLE -(accept)-> SHIFT -(WIDTH bits sent)-> GAP -(GAP_CYCLES done)-> IDLE.
//    If GAP_CYCLES=0, SHIFT -> IDLE directly. done still pulses for 1 cycle, in IDLE.
//  - SHIFT: the cycle after accept carries the first bit.
//    Bit k (k=0..WIDTH-1) is on sdata in cycle k+1 after accept. sframe=1, busy=1 for those WIDTH cycles.
//  - Bit order: MSB_FIRST=0 shifts right and sends in_data[0] first.
//    MSB_FIRST=1 shifts left and sends in_data[WIDTH-1] first.
//  - Bit counter: $clog2(WIDTH) bits; the terminal count is WIDTH-1. No wrap in other states.
//  - done: asserted in cycle WIDTH+1 after accept, simultaneous with the first GAP (or IDLE) cycle.
//  - GAP: sframe=0, sdata=0, busy=1 for exactly GAP_CYCLES cycles.
//  - Throughput: one word per WIDTH+GAP_CYCLES+1 cycles with in_valid held high.
//  - in_valid while busy: not accepted, no side effects. Upstream must hold in_data/in_valid until accepted.
//  - in_data changes after accept: ignored; the transmitted word equals the value at accept.
//  - Reset mid-word: the word is discarded. sframe drops asynchronously. No done pulse.
//    After rst is released, transfer restarts from IDLE.
//  - Outside SHIFT, sdata=0 (line idles low).
// STRUCTURE
//  - Package serial_link_pkg:
//    state encoding localparams ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_GAP=2'd2;
//    the default WIDTH of 8, shared with the receiver so the two ends agree on framing.
//  - Sub-module piso_shift_reg #(WIDTH, MSB_FIRST): load/shift enables, async active-low reset.
//    Exposes the current serial bit.
//  - Top level holds the FSM, bit and gap counters, and output registers.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with in_valid=1 -> all outputs 0, no accept.
//     Release -> in_ready=1 next cycle.
//  2. Single word: WIDTH=8, MSB_FIRST=0, in_data=8'hA5 -> sdata 1,0,1,0,0,1,0,1 over 8 cycles, sframe=1;
//     done=1 in cycle 9; in_ready=1 in cycle 10 (GAP=1).
//  3. MSB_FIRST=1, in_data=8'hA5 -> sdata 1,0,1,0,0,1,0,1 read as bit7..bit0.
//     Also in_data=8'h01 -> sdata seven 0s then 1.
//  4. Back-to-back: in_valid held high with 8'hFF then 8'h00 -> exactly 10 cycles from accept to accept;
//     no sframe between words except the 1 GAP cycle of sframe=0.
//  5. Busy ignore: change in_data to 8'h3C and pulse in_valid in SHIFT cycle 3 -> the original word
//     is fully sent and 8'h3C is not sent.
//  6. Mid-word reset: assert rst=0 at bit 4 of 8'hF0 -> sframe=0 immediately, no done.
//     After release, a new word 8'h81 is sent correctly.

Source files
------------

// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the bit-serial link: FSM states and default word width.
package serial_link_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in, serial-out shift register with zero fill; the serial bit is taken straight from the register.
module piso_shift_reg #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_bit
);

    logic [WIDTH-1:0] data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= MSB_FIRST ? {data[WIDTH-2:0], 1'b0} : {1'b0, data[WIDTH-1:1]};
        end
    end

    assign serial_bit = MSB_FIRST ? data[WIDTH-1] : data[0];

endmodule

// File: rtl/serial_word_tx.sv
// Word transmitter: valid/ready load, WIDTH serial bit cycles framed by sframe, then GAP_CYCLES idle cycles.
module serial_word_tx
    import serial_link_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sdata,
    output logic             sframe,
    output logic             busy,
    output logic             done
);

    localparam int unsigned           CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]      BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [3:0]            GAP_LAST = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_state_e        state, state_next;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_next;
    logic [3:0]       gap_cnt, gap_cnt_next;
    logic             run;
    logic             load, shift, last_bit;

    // run holds in_ready low until the first edge after reset is released.
    assign in_ready = (state == ST_IDLE) && run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            run     <= 1'b0;
            sframe  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_next;
            bit_cnt <= bit_cnt_next;
            gap_cnt <= gap_cnt_next;
            run     <= 1'b1;
            sframe  <= (state_next == ST_SHIFT);
            busy    <= (state_next != ST_IDLE);
            done    <= last_bit;
        end
    end

    always_comb begin
        state_next   = state;
        bit_cnt_next = bit_cnt;
        gap_cnt_next = gap_cnt;
        load         = 1'b0;
        shift        = 1'b0;
        last_bit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    load         = 1'b1;
                    bit_cnt_next = '0;
                    state_next   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift = 1'b1;
                if (bit_cnt == BIT_LAST) begin
                    last_bit     = 1'b1;
                    bit_cnt_next = '0;
                    gap_cnt_next = '0;
                    state_next   = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
                end else begin
                    bit_cnt_next = bit_cnt + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Zero fill empties the register on the last shift, so sdata idles low outside SHIFT.
    piso_shift_reg #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (in_data),
        .serial_bit(sdata)
    );

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: an LSB-first and an MSB-first instance share clock and reset.
module tb_serial_word_tx;

    logic       clk;
    logic       rst;
    logic [7:0] l_data, m_data;
    logic       l_valid, m_valid;
    logic       l_ready, m_ready;
    logic       l_sdata, m_sdata, l_sframe, m_sframe, l_busy, m_busy, l_done, m_done;

    bit l_q[$];
    bit m_q[$];
    bit l_prev, m_prev;
    int checks, errors;

    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .GAP_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .in_data(l_data), .in_valid(l_valid), .in_ready(l_ready),
        .sdata(l_sdata), .sframe(l_sframe), .busy(l_busy), .done(l_done)
    );

    serial_word_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .GAP_CYCLES(1)) dut_msb (
        .clk(clk), .rst(rst), .in_data(m_data), .in_valid(m_valid), .in_ready(m_ready),
        .sdata(m_sdata), .sframe(m_sframe), .busy(m_busy), .done(m_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic mon_lane(input bit sel, input logic sd, input logic sf, input logic dn);
        string tag = sel ? "msb" : "lsb";
        bit    prev = sel ? m_prev : l_prev;
        bit    e;
        int    depth = sel ? m_q.size() : l_q.size();
        if (sf) begin
            if (depth == 0) begin
                check({tag, "_unexpected_frame_bit"}, 32'(depth), 32'd1);
            end else begin
                if (sel) e = m_q.pop_front();
                else     e = l_q.pop_front();
                check({tag, "_sdata"}, 32'(sd), 32'(e));
            end
        end else begin
            check({tag, "_sdata_idle"}, 32'(sd), 32'd0);
        end
        if (prev && !sf)
            check({tag, "_done_pulse"}, 32'(dn), 32'd1);
        else if (dn)
            check({tag, "_done_spurious"}, 32'(dn), 32'd0);
        if (sel) m_prev = sf;
        else     l_prev = sf;
    endtask

    // Monitor: samples on the falling edge, pops expected bits whenever sframe is high.
    always @(negedge clk) begin
        if (!rst) begin
            check("rst_lsb_sframe", 32'(l_sframe), 32'd0);
            check("rst_lsb_busy",   32'(l_busy),   32'd0);
            check("rst_lsb_done",   32'(l_done),   32'd0);
            check("rst_lsb_sdata",  32'(l_sdata),  32'd0);
            check("rst_lsb_ready",  32'(l_ready),  32'd0);
            check("rst_msb_sframe", 32'(m_sframe), 32'd0);
            check("rst_msb_busy",   32'(m_busy),   32'd0);
            check("rst_msb_ready",  32'(m_ready),  32'd0);
            l_prev = 1'b0;
            m_prev = 1'b0;
        end else begin
            mon_lane(1'b0, l_sdata, l_sframe, l_done);
            mon_lane(1'b1, m_sdata, m_sframe, m_done);
        end
    end

    // exp_seq[7] is the first bit expected on the line. Returns at the falling edge of cycle 1.
    task automatic send(input bit sel, input logic [7:0] word, input logic [7:0] exp_seq,
                        output time acc_time);
        bit ok = 1'b0;
        acc_time = 0;
        if (sel) begin m_data = word; m_valid = 1'b1; end
        else     begin l_data = word; l_valid = 1'b1; end
        for (int n = 0; n < 40 && !ok; n++) begin
            if (sel ? m_ready : l_ready) begin
                @(posedge clk);
                acc_time = $time;
                for (int i = 7; i >= 0; i--) begin
                    if (sel) m_q.push_back(exp_seq[i]);
                    else     l_q.push_back(exp_seq[i]);
                end
                ok = 1'b1;
            end
            @(negedge clk);
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        if (sel) m_valid = 1'b0;
        else     l_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit idle = 1'b0;
        for (int n = 0; n < 60 && !idle; n++) begin
            @(negedge clk);
            idle = l_ready && m_ready && (l_q.size() == 0) && (m_q.size() == 0);
        end
        if (!idle) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        time t0, t1;
        int  first_ready;
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        l_data  = 8'hA5;  m_data  = 8'hA5;
        l_valid = 1'b1;   m_valid = 1'b1;

        // 1. reset with in_valid high, then release
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        l_valid = 1'b0;
        m_valid = 1'b0;
        @(negedge clk);
        check("ready_after_release_lsb", 32'(l_ready), 32'd1);
        check("ready_after_release_msb", 32'(m_ready), 32'd1);

        // 2. single word, LSB first, done in cycle 9, ready in cycle 10
        send(1'b0, 8'hA5, 8'b1010_0101, t0);
        first_ready = 0;
        for (int i = 2; i <= 14 && first_ready == 0; i++) begin
            @(negedge clk);
            if (i == 9) begin
                check("done_cycle9", 32'(l_done), 32'd1);
                check("busy_cycle9", 32'(l_busy), 32'd1);
                check("sframe_cycle9", 32'(l_sframe), 32'd0);
            end
            if (l_ready) first_ready = i;
        end
        check("ready_cycle", 32'(first_ready), 32'd10);
        check("busy_cycle10", 32'(l_busy), 32'd0);
        wait_idle();

        send(1'b0, 8'hC4, 8'b0010_0011, t0);
        wait_idle();

        // 3. MSB first
        send(1'b1, 8'hA5, 8'b1010_0101, t0);
        wait_idle();
        send(1'b1, 8'h01, 8'b0000_0001, t0);
        wait_idle();
        send(1'b1, 8'hC4, 8'b1100_0100, t0);
        wait_idle();

        // 4. back-to-back
        send(1'b0, 8'hFF, 8'hFF, t0);
        send(1'b0, 8'h00, 8'h00, t1);
        check("accept_to_accept_cycles", 32'((t1 - t0) / 10), 32'd10);
        wait_idle();

        // 5. in_valid pulsed while busy is ignored
        send(1'b0, 8'h1E, 8'b0111_1000, t0);
        repeat (2) @(negedge clk);
        l_data  = 8'h3C;
        l_valid = 1'b1;
        check("busy_in_shift", 32'(l_busy), 32'd1);
        check("not_ready_in_shift", 32'(l_ready), 32'd0);
        @(negedge clk);
        l_valid = 1'b0;
        l_data  = 8'h00;
        wait_idle();

        // 6. reset during bit 4 of 8'hF0
        send(1'b0, 8'hF0, 8'b0000_1111, t0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        l_q.delete();
        #1;
        check("async_sframe_drop", 32'(l_sframe), 32'd0);
        check("async_busy_drop", 32'(l_busy), 32'd0);
        check("async_done_low", 32'(l_done), 32'd0);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("ready_after_midword_reset", 32'(l_ready), 32'd1);
        send(1'b0, 8'h81, 8'b1000_0001, t0);
        wait_idle();

        check("lsb_queue_drained", 32'(l_q.size()), 32'd0);
        check("msb_queue_drained", 32'(m_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
